// File: rtl/utf16_encoder_if.sv
// Handshake bundle between a scalar producer/consumer and the UTF-16 encoder.
// The master drives the strobes and the scalar; the slave returns the registered code unit and status.
interface utf16_encoder_if #(
    parameter int unsigned COUNT_WIDTH = 16
);
    logic                   allow;
    logic [20:0]            code_point;
    logic                   next;
    logic [15:0]            unit;
    logic                   last;
    logic [1:0]             status;
    logic [COUNT_WIDTH-1:0] unit_count;

    modport master (
        output allow, code_point, next,
        input  unit, last, status, unit_count
    );

    modport slave (
        input  allow, code_point, next,
        output unit, last, status, unit_count
    );
endinterface

// File: rtl/utf16_encoder.sv
// Encodes 21-bit Unicode scalars into UTF-16 code units.
// Surrogate pairs are released one unit at a time, and the low unit waits for the consumer's next strobe.
module utf16_encoder #(
    parameter bit          STRICT      = 1'b1,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic            clock,
    input  logic            reset,
    utf16_encoder_if.slave  bus
);
    localparam logic [20:0] CP_MAX      = 21'h10FFFF;
    localparam logic [20:0] CP_BMP_MAX  = 21'h00FFFF;
    localparam logic [20:0] CP_SUR_LO   = 21'h00D800;
    localparam logic [20:0] CP_SUR_HI   = 21'h00DFFF;
    localparam logic [20:0] CP_SUPP_OFS = 21'h010000;
    localparam logic [1:0]  ST_INITIAL  = 2'd0;
    localparam logic [1:0]  ST_READY    = 2'd2;
    localparam logic [1:0]  ST_ERROR    = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SINGLE,
        S_HIGH,
        S_LOW,
        S_ERR
    } state_t;

    state_t                 state_q, state_d;
    logic [15:0]            unit_q, unit_d;
    logic [9:0]             low_q, low_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [1:0]             status_q, status_d;
    logic                   last_q, last_d;

    logic [19:0] v_c;
    logic        accept_c;
    logic        present_c;
    logic        surrogate_c;

    assign v_c         = 20'(bus.code_point - CP_SUPP_OFS);
    assign surrogate_c = (bus.code_point >= CP_SUR_LO) && (bus.code_point <= CP_SUR_HI);
    assign accept_c    = bus.allow &&
                         ((state_q == S_IDLE) || (state_q == S_SINGLE) || (state_q == S_LOW));

    // State register; reset also drops any pending low surrogate.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            unit_q   <= '0;
            low_q    <= '0;
            count_q  <= '0;
            status_q <= ST_INITIAL;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            unit_q   <= unit_d;
            low_q    <= low_d;
            count_q  <= count_d;
            status_q <= status_d;
            last_q   <= last_d;
        end
    end

    // Next-state, next-unit and registered-output decode.
    always_comb begin
        state_d   = state_q;
        unit_d    = unit_q;
        low_d     = low_q;
        count_d   = count_q;
        status_d  = status_q;
        last_d    = last_q;
        present_c = 1'b0;

        unique case (state_q)
            S_HIGH: begin
                // next outranks allow so a pending pair is never overwritten
                if (bus.next) begin
                    state_d   = S_LOW;
                    unit_d    = 16'hDC00 | {6'b0, low_q};
                    present_c = 1'b1;
                end
            end
            S_ERR: begin
            end
            S_IDLE, S_SINGLE, S_LOW: begin
                if (accept_c) begin
                    if (bus.code_point > CP_MAX) begin
                        state_d = S_ERR;
                    end else if (STRICT && surrogate_c) begin
                        state_d = S_ERR;
                    end else if (bus.code_point <= CP_BMP_MAX) begin
                        state_d   = S_SINGLE;
                        unit_d    = bus.code_point[15:0];
                        present_c = 1'b1;
                    end else begin
                        state_d   = S_HIGH;
                        unit_d    = 16'hD800 | {6'b0, v_c[19:10]};
                        low_d     = v_c[9:0];
                        present_c = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (present_c && (count_q != {COUNT_WIDTH{1'b1}})) begin
            count_d = count_q + COUNT_WIDTH'(1);
        end

        unique case (state_d)
            S_IDLE:   begin status_d = ST_INITIAL; last_d = 1'b0; end
            S_SINGLE: begin status_d = ST_READY;   last_d = 1'b1; end
            S_HIGH:   begin status_d = ST_READY;   last_d = 1'b0; end
            S_LOW:    begin status_d = ST_READY;   last_d = 1'b1; end
            S_ERR:    begin status_d = ST_ERROR;   last_d = 1'b0; end
            default:  begin status_d = ST_INITIAL; last_d = 1'b0; end
        endcase
    end

    assign bus.unit       = unit_q;
    assign bus.last       = last_q;
    assign bus.status     = status_q;
    assign bus.unit_count = count_q;

endmodule
